// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// A misprediction squashes delivery of an outstanding miss; the fill always completes.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] inst_addr_in,
  input  logic        branch_flag_in,
  output logic        inst_done_out,
  output logic [31:0] inst_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic [31:0] mem_inst_in,
  input  logic        mem_done_in
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_e;

  state_e                state_q, state_d;
  logic [31:2]           miss_addr_q, miss_addr_d;
  logic                  done_q, done_d;
  logic [31:0]           inst_q, inst_d;
  logic                  fill_en;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  hit;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^inst_addr_in[1:0];

  assign req_idx  = inst_addr_in[INDEX_BITS+1:2];
  assign req_tag  = inst_addr_in[ADDR_BITS-1:INDEX_BITS+2];
  assign fill_idx = miss_addr_q[INDEX_BITS+1:2];
  assign fill_tag = miss_addr_q[ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    done_d      = 1'b0;
    inst_d      = inst_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_in && !branch_flag_in) begin
          if (hit) begin
            done_d = 1'b1;
            inst_d = data_q[req_idx];
          end else begin
            miss_addr_d = inst_addr_in[31:2];
            state_d     = MISS;
          end
        end
      end
      MISS: begin
        if (mem_done_in) begin
          fill_en = 1'b1;
          state_d = IDLE;
          if (!branch_flag_in) begin
            done_d = 1'b1;
            inst_d = mem_inst_in;
          end
        end else if (branch_flag_in) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_done_in) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      done_q      <= 1'b0;
      inst_q      <= '0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      done_q      <= done_d;
      inst_q      <= inst_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst_in;
    end
  end

  // A flush arriving while a hit pulse is on the wire kills that pulse.
  assign inst_done_out = done_q & ~(branch_flag_in & rdy_in);
  assign inst_out      = inst_q;
  assign mem_req_out   = (state_q == MISS) || (state_q == DROP);
  assign mem_addr_out  = {miss_addr_q, 2'b00};
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflicts, flushes, pause, reset mid-miss.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, if_req, branch, mem_done;
  logic [31:0] addr, mem_inst;
  logic        inst_done, mem_req;
  logic [31:0] inst, mem_addr;
  int          checks = 0;
  int          errors = 0;

  icache #(.INDEX_BITS(7), .ADDR_BITS(18)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .if_req_in(if_req),
    .inst_addr_in(addr), .branch_flag_in(branch),
    .inst_done_out(inst_done), .inst_out(inst),
    .mem_req_out(mem_req), .mem_addr_out(mem_addr),
    .mem_inst_in(mem_inst), .mem_done_in(mem_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Request addr, expect a miss, return data, expect a one-cycle done pulse.
  task automatic fill_miss(input string tag, input logic [31:0] a, input logic [31:0] d);
    if_req = 1'b1; addr = a;
    tick();
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
    chk({tag, "_nodone"}, inst_done, 0);
    mem_done = 1'b1; mem_inst = d;
    tick();
    mem_done = 1'b0; if_req = 1'b0;
    chk({tag, "_done"}, inst_done, 1);
    chk({tag, "_inst"}, inst, d);
    chk({tag, "_reqoff"}, mem_req, 0);
    tick();
    chk({tag, "_pulse1"}, inst_done, 0);
  endtask

  task automatic hit(input string tag, input logic [31:0] a, input logic [31:0] d);
    if_req = 1'b1; addr = a;
    tick();
    if_req = 1'b0;
    chk({tag, "_done"}, inst_done, 1);
    chk({tag, "_inst"}, inst, d);
    chk({tag, "_noreq"}, mem_req, 0);
    tick();
    chk({tag, "_pulse1"}, inst_done, 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; branch = 1'b0; mem_done = 1'b0;
    addr = '0; mem_inst = '0;
    tick(); tick();
    chk("rst_done", inst_done, 0);
    chk("rst_inst", inst, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_memaddr", mem_addr, 0);
    rst = 1'b0;
    tick();

    // Cold miss then hit
    fill_miss("cold", 32'h0000_0000, 32'h0000_0093);
    hit("rehit", 32'h0000_0000, 32'h0000_0093);

    // Conflict eviction: 0x004 and 0x204 share index 1
    fill_miss("c4", 32'h0000_0004, 32'h1111_1111);
    hit("c4hit", 32'h0000_0007, 32'h1111_1111);
    fill_miss("c204", 32'h0000_0204, 32'h2222_2222);
    fill_miss("c4again", 32'h0000_0004, 32'h1111_1111);

    // Flush during miss: fill lands, no delivery
    if_req = 1'b1; addr = 32'h0000_0100;
    tick();
    chk("fl_req", mem_req, 1);
    branch = 1'b1;
    tick();
    branch = 1'b0; if_req = 1'b0;
    chk("fl_drop_req", mem_req, 1);
    chk("fl_drop_addr", mem_addr, 32'h0000_0100);
    branch = 1'b1; // ignored in DROP
    tick();
    branch = 1'b0;
    chk("fl_drop_req2", mem_req, 1);
    mem_done = 1'b1; mem_inst = 32'hDEAD_BEEF;
    tick();
    mem_done = 1'b0;
    chk("fl_nodone", inst_done, 0);
    chk("fl_reqoff", mem_req, 0);
    tick();
    chk("fl_nodone2", inst_done, 0);
    hit("fl_hit", 32'h0000_0100, 32'hDEAD_BEEF);

    // Branch and mem_done together
    if_req = 1'b1; addr = 32'h0000_0200;
    tick();
    chk("sim_req", mem_req, 1);
    branch = 1'b1; mem_done = 1'b1; mem_inst = 32'hCAFE_0001; if_req = 1'b0;
    tick();
    branch = 1'b0; mem_done = 1'b0;
    chk("sim_nodone", inst_done, 0);
    chk("sim_reqoff", mem_req, 0);
    tick();
    chk("sim_nodone2", inst_done, 0);
    hit("sim_hit", 32'h0000_0200, 32'hCAFE_0001);

    // Pause in MISS: mem_done ignored while rdy low
    if_req = 1'b1; addr = 32'h0000_0300;
    tick();
    chk("ps_req", mem_req, 1);
    rdy = 1'b0; mem_done = 1'b1; mem_inst = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ps_hold_req", mem_req, 1);
      chk("ps_hold_done", inst_done, 0);
    end
    rdy = 1'b1; mem_done = 1'b0;
    tick();
    chk("ps_still_miss", mem_req, 1);
    mem_done = 1'b1; mem_inst = 32'h1234_5678;
    tick();
    mem_done = 1'b0; if_req = 1'b0;
    chk("ps_done", inst_done, 1);
    chk("ps_inst", inst, 32'h1234_5678);
    tick();
    hit("ps_hit", 32'h0000_0300, 32'h1234_5678);

    // Reset mid-miss clears pending fill and all valid bits
    if_req = 1'b1; addr = 32'h0000_0008;
    tick();
    chk("rm_req", mem_req, 1);
    rst = 1'b1; if_req = 1'b0;
    tick();
    chk("rm_reqoff", mem_req, 0);
    chk("rm_done", inst_done, 0);
    rst = 1'b0;
    tick();
    fill_miss("rm_remiss", 32'h0000_0100, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the IF stage and `mem_ctrl` on the fetch path inside `cpu`. IF issues word-aligned fetch requests. Hits return the instruction one cycle later. Misses issue a single 32-bit fetch to `mem_ctrl`, fill the line, then return. A branch misprediction (`branch_flag_in`) squashes the delivery of an outstanding miss but still lets the fill complete, because `mem_ctrl` cannot abort a transfer.

## Interface
- `INDEX_BITS`, default 7: line-index width; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
- `ADDR_BITS`, default 18: significant address bits. Tag is `addr[ADDR_BITS-1 : 2+INDEX_BITS]`.

Ports:
- `clk_in` input, 1 bit: system clock; the only clock.
- `rst_in` input, 1 bit: reset, synchronous, active-high.
- `rdy_in` input, 1 bit: pause when low. All state and outputs hold.
- `if_req_in` input, 1 bit: fetch request from IF. Held high until `inst_done_out`.
- `inst_addr_in` input, 32 bits: fetch address; bits [1:0] are ignored.
- `branch_flag_in` input, 1 bit: misprediction flush pulse.
- `inst_done_out` output, 1 bit: one-cycle pulse; `inst_out` is valid.
- `inst_out` output, 32 bits: fetched instruction.
- `mem_req_out` output, 1 bit: fetch request to `mem_ctrl`.
- `mem_addr_out` output, 32 bits: word address of the miss, with [1:0]=0.
- `mem_inst_in` input, 32 bits: word returned by `mem_ctrl`.
- `mem_done_in` input, 1 bit: one-cycle pulse; `mem_inst_in` is valid.

## Operation
- Storage per line: valid bit, tag, and 32-bit data. Valid bits are cleared by reset only. There is no store snooping; self-modifying code is unsupported.
- FSM states: `IDLE`, `MISS`, `DROP`.
- In `IDLE` with `if_req_in=1` and `branch_flag_in=0`:
  - hit (valid and tag match): register the data and pulse `inst_done_out` next cycle; stay in `IDLE`.
  - miss: latch the address into `miss_addr` and go to `MISS`.
- `MISS`:
  - `mem_req_out=1` and `mem_addr_out=miss_addr`.
  - On `mem_done_in`: write the line (valid=1, tag, data), drive `inst_out=mem_inst_in`, pulse `inst_done_out` next cycle, and go to `IDLE`.
  - On `branch_flag_in` without `mem_done_in`: go to `DROP`.
  - If `branch_flag_in` and `mem_done_in` occur in the same cycle: fill the line, suppress `inst_done_out`, and go to `IDLE`.
- `DROP`:
  - `mem_req_out` stays 1 with the same address.
  - On `mem_done_in`: fill the line, no `inst_done_out`, go to `IDLE`.
  - Further `branch_flag_in` pulses are ignored.
- `branch_flag_in` in `IDLE`: the request that cycle is ignored (no lookup, no pulse). A hit pulse already registered for the next cycle is suppressed.
- Changes to `inst_addr_in` while in `MISS` or `DROP` are ignored. The new address is looked up on return to `IDLE`.
- `rdy_in=0`: the FSM, line array, and output registers are frozen. `mem_done_in` and `branch_flag_in` are not sampled.

## Timing
- Reset values: `inst_done_out=0`, `inst_out=0`, `mem_req_out=0`, `mem_addr_out=0`, state `IDLE`, all valid bits 0.
- Reset mid-miss: back to `IDLE` in one cycle with `mem_req_out=0`. The pending fill is discarded.
- Hit latency: request sampled at edge T; `inst_done_out=1` during cycle T+1 only.
- Miss latency:
  - `mem_req_out` rises during cycle T+1.
  - `mem_done_in` is sampled at edge D; `mem_req_out=0` and `inst_done_out=1` during cycle D+1.
  - Earliest next lookup is at edge D+1.
- A fill and a lookup of the same index never occur in the same cycle; lookups happen only in `IDLE`.
- Back-to-back hits: one instruction per cycle is possible only if IF re-requests in the cycle after the pulse. Throughput is one hit per 2 cycles when IF drops `if_req_in` after done.
- Index is `addr[INDEX_BITS+1:2]`. Addresses are compared modulo 2^ADDR_BITS.

## Test plan
- Cold miss: reset, then request 0x00000000.
  - `mem_req_out` with address 0x0 next cycle.
  - `mem_done_in` with 0x00000093 → `inst_done_out` pulse with `inst_out`=0x00000093.
  - Re-request 0x0 → hit pulse one cycle after the request, no `mem_req_out`.
- Conflict eviction: fill 0x0004, then request 0x0204 (same index at `INDEX_BITS`=7) → miss; after the fill, 0x0004 misses again.
- Flush during miss: request 0x0100, pulse `branch_flag_in` while in `MISS`.
  - `mem_done_in` with 0xDEADBEEF produces no `inst_done_out`.
  - Next request to 0x0100 hits with 0xDEADBEEF.
- Simultaneous `branch_flag_in` and `mem_done_in` → line filled, no pulse, state `IDLE`.
- Pause: hold `rdy_in=0` for 5 cycles in `MISS` while pulsing `mem_done_in` → ignored. With `rdy_in=1`, the next `mem_done_in` completes normally.
- Reset mid-miss: assert `rst_in` in `MISS` → `mem_req_out=0` next cycle; a previously cached line now misses.
